// File: rtl/div_unit_pkg.sv
// div_unit_pkg
//   Shared constants, state encoding and a helper for the EX-stage divider.
//   Contents:
//     div_state_e              2-bit divider state codes
//     ZeroWord                 32-bit zero
//     DivResultReady/NotReady  ready_o levels
//     DivStart/DivStop         start_i levels
//     neg_if()                 conditional two's-complement negate
package div_unit_pkg;

    typedef enum logic [1:0] {
        DivFree   = 2'b00,
        DivByZero = 2'b01,
        DivOn     = 2'b10,
        DivEnd    = 2'b11
    } div_state_e;

    localparam logic [31:0] ZeroWord          = 32'h0000_0000;
    localparam logic        DivResultReady    = 1'b1;
    localparam logic        DivResultNotReady = 1'b0;
    localparam logic        DivStart          = 1'b1;
    localparam logic        DivStop           = 1'b0;
    localparam logic [5:0]  DivSteps          = 6'd32;

    // Negating 0x80000000 yields 0x80000000, which is exactly the
    // magnitude wanted for the most negative operand.
    function automatic logic [31:0] neg_if(input logic [31:0] x, input logic en);
        return en ? (~x + 32'd1) : x;
    endfunction

endpackage

// File: rtl/div_unit.sv
// div_unit
//   Multi-cycle 32-bit radix-2 restoring divider (DIV / DIVU) for the EX stage.
//   One quotient bit per cycle; result valid 33 edges after the start edge.
//   Ports:
//     clk           system clock, rising edge
//     rst           asynchronous active-low reset
//     signed_div_i  1 = signed (DIV), 0 = unsigned (DIVU)
//     opdata1_i     dividend
//     opdata2_i     divisor
//     start_i       request, held high until the result is consumed
//     annul_i       abort (flush / exception)
//     result_o      {remainder, quotient}
//     ready_o       result valid, high only in DivEnd
//
//   state     | meaning
//   DivFree   | idle, waiting for start_i
//   DivByZero | divisor was zero, result forced to 0
//   DivOn     | iterating, cnt counts completed quotient bits
//   DivEnd    | result valid until start_i drops or annul_i
module div_unit
    import div_unit_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        signed_div_i,
    input  logic [31:0] opdata1_i,
    input  logic [31:0] opdata2_i,
    input  logic        start_i,
    input  logic        annul_i,
    output logic [63:0] result_o,
    output logic        ready_o
);

    div_state_e  state;
    div_state_e  state_next;
    logic [5:0]  cnt;
    logic [31:0] divisor;
    logic [63:0] sr;        // {partial remainder, dividend/quotient bits}
    logic        neg_q;
    logic        neg_r;
    logic [31:0] mag1;
    logic [31:0] mag2;
    logic [32:0] diff;
    logic        take;
    logic        go;

    assign go   = (start_i == DivStart) && !annul_i;
    assign mag1 = neg_if(opdata1_i, signed_div_i & opdata1_i[31]);
    assign mag2 = neg_if(opdata2_i, signed_div_i & opdata2_i[31]);

    // The shifted partial remainder is 33 bits (sr[63:31]). Its top bit set
    // means it certainly exceeds the divisor; otherwise the low 32 bits are
    // trial-subtracted. Either way diff[31:0] is the correct new remainder.
    assign diff = {1'b0, sr[62:31]} - {1'b0, divisor};
    assign take = sr[63] | ~diff[32];

    assign ready_o = (state == DivEnd) ? DivResultReady : DivResultNotReady;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= DivFree;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            DivFree: begin
                if (go) begin
                    state_next = (opdata2_i == ZeroWord) ? DivByZero : DivOn;
                end
            end
            DivByZero: state_next = DivEnd;
            DivOn: begin
                if (annul_i) begin
                    state_next = DivFree;
                end else if (cnt == DivSteps) begin
                    state_next = DivEnd;
                end
            end
            DivEnd: begin
                if (annul_i || (start_i == DivStop)) begin
                    state_next = DivFree;
                end
            end
            default: state_next = DivFree;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt      <= 6'd0;
            divisor  <= ZeroWord;
            sr       <= 64'd0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            result_o <= 64'd0;
        end else begin
            case (state)
                DivFree: begin
                    if (go && (opdata2_i != ZeroWord)) begin
                        cnt     <= 6'd0;
                        divisor <= mag2;
                        sr      <= {ZeroWord, mag1};
                        neg_q   <= signed_div_i & (opdata1_i[31] ^ opdata2_i[31]);
                        neg_r   <= signed_div_i & opdata1_i[31];
                    end
                end
                DivByZero: result_o <= 64'd0;
                DivOn: begin
                    if (!annul_i) begin
                        if (cnt != DivSteps) begin
                            sr  <= take ? {diff[31:0], sr[30:0], 1'b1}
                                        : {sr[62:0], 1'b0};
                            cnt <= cnt + 6'd1;
                        end else begin
                            result_o <= {neg_if(sr[63:32], neg_r),
                                         neg_if(sr[31:0], neg_q)};
                        end
                    end
                end
                DivEnd: begin
                    if (annul_i || (start_i == DivStop)) begin
                        result_o <= 64'd0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_div_unit.sv
module tb_div_unit;

    logic        clk;
    logic        rst;
    logic        signed_div_i;
    logic [31:0] opdata1_i;
    logic [31:0] opdata2_i;
    logic        start_i;
    logic        annul_i;
    logic [63:0] result_o;
    logic        ready_o;

    int total;
    int bad;

    div_unit dut (
        .clk          (clk),
        .rst          (rst),
        .signed_div_i (signed_div_i),
        .opdata1_i    (opdata1_i),
        .opdata2_i    (opdata2_i),
        .start_i      (start_i),
        .annul_i      (annul_i),
        .result_o     (result_o),
        .ready_o      (ready_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: plain integer division, quotient truncated toward zero,
    // remainder takes the dividend's sign; x/0 gives 0; MIN/-1 wraps.
    function automatic logic [63:0] ref_div(input logic s, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] q;
        logic [31:0] r;
        if (b == 32'd0) return 64'd0;
        if (!s) begin
            q = a / b;
            r = a % b;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            q = 32'h8000_0000;
            r = 32'd0;
        end else begin
            q = $signed(a) / $signed(b);
            r = $signed(a) % $signed(b);
        end
        return {r, q};
    endfunction

    function automatic int exp_lat(input logic [31:0] b);
        return (b == 32'd0) ? 1 : 33;
    endfunction

    // Drives one division. Called at posedge+1. lat = edges after the
    // sampling edge E0 until ready_o is seen (capped at 60). Operands are
    // scrambled after E0. After the result, start_i drops for one edge and
    // the outputs after that edge are returned.
    task automatic run_div(input logic s, input logic [31:0] a, input logic [31:0] b,
                           output int lat, output logic [63:0] res,
                           output logic drop_rdy, output logic [63:0] drop_res);
        signed_div_i = s;
        opdata1_i    = a;
        opdata2_i    = b;
        start_i      = 1'b1;
        @(posedge clk); #1;
        opdata1_i    = $urandom;
        opdata2_i    = $urandom;
        signed_div_i = ~s;
        lat = 0;
        while (!ready_o && lat < 60) begin
            @(posedge clk); #1;
            lat++;
        end
        res = result_o;
        start_i = 1'b0;
        @(posedge clk); #1;
        drop_rdy = ready_o;
        drop_res = result_o;
    endtask

    task automatic test_reset;
        rst = 1'b0;
        signed_div_i = 1'b0;
        opdata1_i = '0;
        opdata2_i = '0;
        start_i = 1'b0;
        annul_i = 1'b0;
        #3;
        total++;
        if (ready_o !== 1'b0) begin bad++; $display("FAIL reset_ready got=%0b want=0", ready_o); end
        total++;
        if (result_o !== 64'd0) begin bad++; $display("FAIL reset_result got=%h want=0", result_o); end
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_directed;
        int lat; logic [63:0] res; logic dr; logic [63:0] dres;
        // DIVU 100 / 7
        run_div(1'b0, 32'd100, 32'd7, lat, res, dr, dres);
        total++;
        if (lat !== 33) begin bad++; $display("FAIL divu_latency got=%0d want=33", lat); end
        total++;
        if (res !== 64'h00000002_0000000E) begin bad++; $display("FAIL divu_result got=%h want=%h", res, 64'h00000002_0000000E); end
        total++;
        if (dr !== 1'b0 || dres !== 64'd0) begin bad++; $display("FAIL divu_drop got=%0b/%h want=0/0", dr, dres); end
        // DIV -7 / 2
        run_div(1'b1, 32'hFFFF_FFF9, 32'd2, lat, res, dr, dres);
        total++;
        if (res !== 64'hFFFFFFFF_FFFFFFFD) begin bad++; $display("FAIL div_signed got=%h want=%h", res, 64'hFFFFFFFF_FFFFFFFD); end
        // DIV MIN / -1
        run_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, lat, res, dr, dres);
        total++;
        if (res !== 64'h00000000_80000000 || lat !== 33) begin bad++; $display("FAIL div_overflow got=%h lat=%0d want=%h lat=33", res, lat, 64'h00000000_80000000); end
        // DIVU 5 / 0
        run_div(1'b0, 32'd5, 32'd0, lat, res, dr, dres);
        total++;
        if (lat !== 1) begin bad++; $display("FAIL divzero_latency got=%0d want=1", lat); end
        total++;
        if (res !== 64'd0) begin bad++; $display("FAIL divzero_result got=%h want=0", res); end
        // Large unsigned divisor exercises the 33-bit partial remainder
        run_div(1'b0, 32'hFFFF_FFFF, 32'h8000_0001, lat, res, dr, dres);
        total++;
        if (res !== ref_div(1'b0, 32'hFFFF_FFFF, 32'h8000_0001)) begin bad++; $display("FAIL divu_bigdiv got=%h want=%h", res, ref_div(1'b0, 32'hFFFF_FFFF, 32'h8000_0001)); end
    endtask

    task automatic test_annul;
        int lat; logic [63:0] res; logic dr; logic [63:0] dres;
        int seen;
        signed_div_i = 1'b0;
        opdata1_i = 32'd1000;
        opdata2_i = 32'd3;
        start_i = 1'b1;
        repeat (11) @(posedge clk);  // E0..E10, cnt = 10
        #1;
        annul_i = 1'b1;
        @(posedge clk); #1;
        annul_i = 1'b0;
        start_i = 1'b0;
        seen = 0;
        repeat (40) begin
            if (ready_o) seen++;
            @(posedge clk); #1;
        end
        total++;
        if (seen !== 0) begin bad++; $display("FAIL annul_mid ready_cycles=%0d want=0", seen); end
        run_div(1'b0, 32'd9, 32'd3, lat, res, dr, dres);
        total++;
        if (res !== 64'h00000000_00000003 || lat !== 33) begin bad++; $display("FAIL after_annul got=%h lat=%0d want=3 lat=33", res, lat); end
        // annul while in END, start still high
        signed_div_i = 1'b0; opdata1_i = 32'd50; opdata2_i = 32'd5; start_i = 1'b1;
        repeat (34) @(posedge clk);
        #1;
        total++;
        if (ready_o !== 1'b1 || result_o !== 64'h00000000_0000000A) begin bad++; $display("FAIL end_hold got=%0b/%h want=1/a", ready_o, result_o); end
        annul_i = 1'b1;
        @(posedge clk); #1;
        total++;
        if (ready_o !== 1'b0 || result_o !== 64'd0) begin bad++; $display("FAIL annul_end got=%0b/%h want=0/0", ready_o, result_o); end
        // start and annul together in FREE: never leaves FREE
        seen = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (ready_o) seen++;
        end
        total++;
        if (seen !== 0) begin bad++; $display("FAIL start_annul_free ready_cycles=%0d want=0", seen); end
        annul_i = 1'b0;
        start_i = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid;
        int lat; logic [63:0] res; logic dr; logic [63:0] dres;
        signed_div_i = 1'b0; opdata1_i = 32'd77; opdata2_i = 32'd4; start_i = 1'b1;
        repeat (21) @(posedge clk);  // cnt = 20
        #2;
        rst = 1'b0;
        #1;
        total++;
        if (ready_o !== 1'b0 || result_o !== 64'd0) begin bad++; $display("FAIL reset_mid got=%0b/%h want=0/0", ready_o, result_o); end
        // reset while a result is being held in END
        rst = 1'b1;
        @(posedge clk);
        repeat (34) @(posedge clk);
        #2;
        total++;
        if (ready_o !== 1'b1 || result_o !== 64'h00000001_00000013) begin bad++; $display("FAIL pre_reset_end got=%0b/%h want=1/%h", ready_o, result_o, 64'h00000001_00000013); end
        rst = 1'b0;
        #1;
        total++;
        if (ready_o !== 1'b0 || result_o !== 64'd0) begin bad++; $display("FAIL reset_end got=%0b/%h want=0/0", ready_o, result_o); end
        start_i = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        run_div(1'b0, 32'd1, 32'd1, lat, res, dr, dres);
        total++;
        if (res !== 64'h00000000_00000001 || lat !== 33) begin bad++; $display("FAIL after_reset got=%h lat=%0d want=1 lat=33", res, lat); end
    endtask

    task automatic test_random;
        int lat; logic [63:0] res; logic dr; logic [63:0] dres;
        logic s; logic [31:0] a; logic [31:0] b;
        for (int i = 0; i < 30; i++) begin
            s = $urandom_range(0, 1);
            a = $urandom;
            case ($urandom_range(0, 4))
                0: b = 32'd0;
                1: b = $urandom_range(1, 15);
                2: b = 32'hFFFF_FFFF - $urandom_range(0, 7);
                default: b = $urandom;
            endcase
            if (i == 0) a = 32'h8000_0000;
            run_div(s, a, b, lat, res, dr, dres);
            total++;
            if (res !== ref_div(s, a, b) || lat !== exp_lat(b)) begin
                bad++;
                $display("FAIL random s=%0b a=%h b=%h got=%h lat=%0d want=%h lat=%0d", s, a, b, res, lat, ref_div(s, a, b), exp_lat(b));
            end
            total++;
            if (dr !== 1'b0 || dres !== 64'd0) begin bad++; $display("FAIL random_drop got=%0b/%h want=0/0", dr, dres); end
        end
    endtask

    initial begin
        total = 0;
        bad = 0;
        test_reset();
        test_directed();
        test_annul();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
